// File: rtl/mux_capture_fifo.sv
// Registered a/b select capture into a circular FIFO with a valid/ready output.
// Optional same-cycle pass-through when empty: define MUX_CAPTURE_FIFO_BYPASS_EN.
module mux_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           y_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             full;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] in_data;

  // Handshake: a beat transfers on any rising edge where valid && ready are
  // both high; valid never depends on ready on the same side of the FIFO.
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign in_data = sel ? b : a;

`ifdef MUX_CAPTURE_FIFO_BYPASS_EN
  // Empty FIFO with a ready consumer: hand the beat straight through.
  assign bypass = empty && in_valid && out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push      = in_valid && !full && !bypass;
  assign pop       = !empty && out_ready;
  assign in_ready  = !full;
  assign out_valid = !empty || bypass;
  assign y_out     = bypass ? in_data : (empty ? '0 : mem[rd_ptr]);
  assign count     = cnt_q;
  assign overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      // Sticky until reset: a refused beat means upstream broke the hold rule.
      if (in_valid && full) ovf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_capture_fifo.sv
// Directed bench for mux_capture_fifo with a reference occupancy model and an
// expected-data queue; honours MUX_CAPTURE_FIFO_BYPASS_EN when defined.
module tb_mux_capture_fifo;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  y_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  int           m_cnt = 0;
  logic         m_ovf = 1'b0;

  mux_capture_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n, input logic v);
    @(negedge clk);
    rst = 1'b1; in_valid = v; out_ready = 1'b0;
    repeat (n) @(posedge clk);
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // One clock: drive at the falling edge, check outputs 1ns later, then
  // advance the model across the rising edge.
  task automatic cycle(input logic v, input logic s, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic r);
    logic         byp;
    logic         push_ok;
    logic         pop_ok;
    logic [W-1:0] exp_y;
    @(negedge clk);
    rst = 1'b0; in_valid = v; sel = s; a = av; b = bv; out_ready = r;
    #1;
`ifdef MUX_CAPTURE_FIFO_BYPASS_EN
    byp = (m_cnt == 0) && v && r;
`else
    byp = 1'b0;
`endif
    if (byp)           exp_y = s ? bv : av;
    else if (m_cnt > 0) exp_y = exp_q[0];
    else               exp_y = '0;
    check("count",     32'(count),     32'(m_cnt));
    check("in_ready",  32'(in_ready),  32'(m_cnt != D));
    check("out_valid", 32'(out_valid), 32'((m_cnt != 0) || byp));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("y_out",     32'(y_out),     32'(exp_y));
    push_ok = v && (m_cnt != D) && !byp;
    pop_ok  = r && (m_cnt != 0);
    @(posedge clk);
    if (v && m_cnt == D) m_ovf = 1'b1;
    if (pop_ok) void'(exp_q.pop_front());
    if (push_ok) exp_q.push_back(s ? bv : av);
    m_cnt = m_cnt + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
  endtask

  initial begin
    logic         s;
    logic [W-1:0] v8;
    logic [W-1:0] junk;

    // Reset: two cycles, then idle observation.
    do_reset(2, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Select capture with the consumer stalled, then drain.
    cycle(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    cycle(1'b1, 1'b0, 8'h33, 8'h44, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Fill past capacity: fifth beat is refused and flags overflow.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, W'(i), 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Streaming through the pointer wrap, random source select.
    do_reset(1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      s    = 1'($urandom_range(0, 1));
      v8   = W'(8'hA0 + i);
      junk = W'($urandom_range(0, 255));
      if (s) cycle(1'b1, 1'b1, junk, v8, 1'b1);
      else   cycle(1'b1, 1'b0, v8, junk, 1'b1);
    end
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Full with a simultaneous pop: push refused, count drops to 3.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'h00, W'(8'hC0 + i), 1'b0);
    cycle(1'b1, 1'b0, 8'hC9, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Mid-stream reset at count 3 with a beat offered during reset.
    do_reset(1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Empty FIFO with valid and ready together (pass-through when enabled).
    cycle(1'b1, 1'b0, 8'h5A, 8'hA5, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux_capture_fifo.md
# mux_capture_fifo

Registered capture stage that replaces level-sensitive select logic with a clocked, flow-controlled path. Each accepted input beat stores `b` when `sel`=1 and `a` when `sel`=0 into a small circular FIFO. The head entry is presented downstream with a valid/ready handshake. It sits directly downstream of the a/b select point and feeds the consumer of `y_out`, so the consumer never sees a held or latched value.

## Interface
Parameters:
- `WIDTH`, default 8: data width of `a`, `b` and `y_out`.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `a`, input, WIDTH: data captured when `sel`=0.
- `b`, input, WIDTH: data captured when `sel`=1.
- `sel`, input, 1: selects the source for the current beat.
- `in_valid`, input, 1: upstream beat present.
- `in_ready`, output, 1: FIFO can accept a beat; equals !full.
- `y_out`, output, WIDTH: head-of-FIFO data.
- `out_valid`, output, 1: `y_out` holds a valid beat.
- `out_ready`, input, 1: downstream accepts the beat.
- `count`, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`, output, 1: sticky flag; set when `in_valid`=1 while `in_ready`=0.

## Operation
- Push occurs when `in_valid && in_ready`. The write data is `sel ? b : a`, written to `mem[wr_ptr]`, and `wr_ptr` increments.
- Pop occurs when `out_valid && out_ready`. `rd_ptr` increments.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; no special wrap handling is needed.
- `count` changes as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on a simultaneous push and pop, or when neither occurs.
- Full is `count==DEPTH`; empty is `count==0`.
- `in_ready` = `count!=DEPTH`. When full, a same-cycle pop does not open `in_ready`; the push is refused that cycle.
- `out_valid` = `count!=0`, except in bypass (see Configuration).
- `y_out` = `mem[rd_ptr]` when not empty, otherwise all zeros. It never shows stale popped data.
- `overflow` is set on any cycle with `in_valid && !in_ready`. It is cleared only by `rst`. The refused beat is dropped, and the upstream must hold it.
- Reset values: `count`=0, `out_valid`=0, `in_ready`=1, `y_out`=0, `overflow`=0, both pointers 0. Memory contents are don't-care.
- Reset mid-operation discards all entries. The cycle after `rst` deasserts starts empty, and any push in the `rst` cycle is ignored.

## Timing
- Push-to-output latency is 1 cycle. A beat pushed at edge N appears on `y_out` with `out_valid`=1 in the cycle after edge N, if the FIFO was empty.
- Throughput is one push and one pop per cycle in steady state (0 < count < DEPTH).
- `in_ready`, `out_valid`, `count` and `overflow` are registered-state-derived only. The sole exception is bypass, below.
- `sel`, `a` and `b` are sampled only at the push edge. Changes at any other time have no effect on stored data.

## Configuration
- `MUX_CAPTURE_FIFO_BYPASS_EN` defined: when the FIFO is empty and `in_valid && out_ready`, the beat passes through in the same cycle.
  - `out_valid`=1 and `y_out`=`sel ? b : a` combinationally.
  - No write occurs, and `count` stays 0.
  - If `out_ready`=0, a normal push occurs instead.
- Not defined: no combinational in→out path. Minimum latency is 1 cycle, as in Timing.

## Test plan
- Reset check: `rst`=1 for 2 cycles, then release. Required: `count`=0, `out_valid`=0, `in_ready`=1, `y_out`=0, `overflow`=0.
- Select capture, with `out_ready`=0:
  - Push `a`=0x11, `b`=0x22, `sel`=1.
  - Then push `a`=0x33, `b`=0x44, `sel`=0.
  - Then assert `out_ready`. Required: `y_out` reads 0x22 then 0x33, `count` goes 2→1→0.
- Fill and overflow, with `out_ready`=0:
  - Push 5 beats 0x01..0x05. Required: `in_ready` low after the 4th, `count`=4, `overflow`=1, and 0x05 is lost.
  - Drain. Required: 0x01..0x04 in order.
- Wrap-around: stream 10 beats 0xA0..0xA9 with `in_valid` and `out_ready` both held high. Required: output order 0xA0..0xA9, `count` ≤1, no `overflow`.
- Full with simultaneous pop: at `count`=4, `in_valid`=1 and `out_ready`=1. Required: pop occurs, push refused, `count`=3, `overflow`=1.
- Mid-stream reset: at `count`=3, assert `rst` one cycle with `in_valid`=1. Required: next cycle `count`=0 and `out_valid`=0. With `MUX_CAPTURE_FIFO_BYPASS_EN`, an empty FIFO with `in_valid` and `out_ready` high and `sel`=0, `a`=0x5A gives `y_out`=0x5A in the same cycle.
